// File: rtl/datapath.sv
// Single-bus CPU datapath: 16-entry register file, special registers,
// 512x32 RAM, ALU with 64-bit Z, and branch-condition flip-flop.
module datapath #(
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
  input  logic              HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout,
  input  logic              Gra, Grb, Grc, Rin, Rout, BAout,
  input  logic              Read,
  input  logic              write,
  input  logic              IncPC,
  input  logic [DATA_W-1:0] inportInput,
  input  logic [15:0]       regIn,
  output logic [DATA_W-1:0] busMuxOut,
  output logic [4:0]        encoderOut,
  output logic              CON,
  output logic [DATA_W-1:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3,
  output logic [DATA_W-1:0] BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7,
  output logic [DATA_W-1:0] BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
  output logic [DATA_W-1:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
  output logic [DATA_W-1:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo,
  output logic [DATA_W-1:0] BusMuxInPC, BusMuxInMDR, BusMuxInInport, BusMuxInOutport, BusMuxInY,
  output logic [DATA_W-1:0] IRregister,
  output logic [DATA_W-1:0] Cregister,
  output logic [8:0]        marToRam
);

  logic [DATA_W-1:0]   r [16];
  logic [DATA_W-1:0]   hi, lo, pc, mdr, mar, ir, y, inport, outport;
  logic [2*DATA_W-1:0] z;
  logic [DATA_W-1:0]   ram [512];
  logic [DATA_W-1:0]   ram_rd;
  logic [DATA_W-1:0]   bus;
  logic [4:0]          enc;
  logic [3:0]          field;
  logic [15:0]         dec;
  logic [25:0]         req;
  logic [DATA_W-1:0]   c_ext;
  logic                cond;
  logic                unused_mar;

  // ALU: A is Y, B is the bus; 32-bit results land in the low half.
  function automatic logic [2*DATA_W-1:0] alu_op(input logic [4:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0]   as_v, bs_v;
    logic signed [2*DATA_W-1:0] ax, bx, prod;
    logic [2*DATA_W-1:0]        rot;
    logic [DATA_W-1:0]          lo_res, hi_res;
    logic [4:0]                 sh;
    as_v   = a;
    bs_v   = b;
    sh     = b[4:0];
    lo_res = '0;
    hi_res = '0;
    rot    = '0;
    ax     = '0;
    bx     = '0;
    prod   = '0;
    case (op)
      5'b00100: lo_res = a - b;
      5'b00101: lo_res = a >> sh;
      5'b00110: lo_res = as_v >>> sh;
      5'b00111: lo_res = a << sh;
      5'b01000: begin
        rot    = {a, a} >> sh;
        lo_res = rot[DATA_W-1:0];
      end
      5'b01001: begin
        rot    = {a, a} << sh;
        lo_res = rot[2*DATA_W-1:DATA_W];
      end
      5'b01010, 5'b01101: lo_res = a & b;
      5'b01011, 5'b01110: lo_res = a | b;
      5'b10001: lo_res = -b;
      5'b10010: lo_res = ~b;
      5'b01111: begin
        ax     = {{DATA_W{a[DATA_W-1]}}, a};
        bx     = {{DATA_W{b[DATA_W-1]}}, b};
        prod   = ax * bx;
        hi_res = prod[2*DATA_W-1:DATA_W];
        lo_res = prod[DATA_W-1:0];
      end
      5'b10000: begin
        if (b != '0) begin
          lo_res = as_v / bs_v;
          hi_res = as_v % bs_v;
        end
      end
      default: lo_res = a + b;
    endcase
    return {hi_res, lo_res};
  endfunction

  assign field  = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign dec    = 16'd1 << field;
  assign c_ext  = {{(DATA_W-19){ir[18]}}, ir[18:0]};
  assign ram_rd = ram[mar[8:0]];

  // Gather every bus-drive request, indexed by its encoder code.
  always_comb begin
    req = '0;
    for (int i = 0; i < 16; i++) req[i] = (Rout | BAout) & dec[i];
    req[16] = HIout;
    req[17] = LOout;
    req[18] = ZHIout;
    req[19] = ZLOout;
    req[20] = PCout;
    req[21] = MDRout;
    req[22] = INPORTout;
    req[23] = Cout;
    req[24] = Yout;
    req[25] = OUTPORTout;
  end

  // Priority encoder: the lowest requesting code wins, 31 when idle.
  always_comb begin
    enc = 5'd31;
    for (int i = 25; i >= 0; i--) begin
      if (req[i]) enc = 5'(i);
    end
  end

  // Bus mux; BAout on R0 forces zero so R0 can act as a base of 0.
  always_comb begin
    bus = '0;
    case (enc)
      5'd16:   bus = hi;
      5'd17:   bus = lo;
      5'd18:   bus = z[2*DATA_W-1:DATA_W];
      5'd19:   bus = z[DATA_W-1:0];
      5'd20:   bus = pc;
      5'd21:   bus = mdr;
      5'd22:   bus = inport;
      5'd23:   bus = c_ext;
      5'd24:   bus = y;
      5'd25:   bus = outport;
      default: begin
        if (enc < 5'd16) bus = (BAout && enc == 5'd0) ? '0 : r[enc[3:0]];
      end
    endcase
  end

  // Branch condition selected by C2.
  always_comb begin
    cond = 1'b0;
    case (ir[20:19])
      2'b00: cond = (bus == '0);
      2'b01: cond = (bus != '0);
      2'b10: cond = ~bus[DATA_W-1];
      2'b11: cond = bus[DATA_W-1];
      default: cond = 1'b0;
    endcase
  end

  // General-purpose registers, loaded via Rin decode or direct regIn.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if ((Rin & dec[i]) | regIn[i]) r[i] <= bus;
      end
    end
  end

  // Special registers, Z, PC (increment beats load), MDR and CON.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      hi      <= '0;
      lo      <= '0;
      z       <= '0;
      pc      <= '0;
      mdr     <= '0;
      mar     <= '0;
      ir      <= '0;
      y       <= '0;
      inport  <= '0;
      outport <= '0;
      CON     <= 1'b0;
    end else begin
      inport <= inportInput;
      if (HIin)      hi      <= bus;
      if (LOin)      lo      <= bus;
      if (Yin)       y       <= bus;
      if (MARin)     mar     <= bus;
      if (IRin)      ir      <= bus;
      if (OUTPORTin) outport <= bus;
      if (Zin)       z       <= alu_op(ir[31:27], y, bus);
      if (MDRin)     mdr     <= Read ? ram_rd : bus;
      if (CONin)     CON     <= cond;
      if (IncPC)     pc      <= pc + 1'b1;
      else if (PCin) pc      <= bus;
    end
  end

  // Memory write from MDR at the MAR address; contents survive Clear.
  always_ff @(posedge Clock) begin
    if (write && Clear) ram[mar[8:0]] <= mdr;
  end

  assign unused_mar = ^mar[DATA_W-1:9];

  assign busMuxOut       = bus;
  assign encoderOut      = enc;
  assign BusMuxInR0      = r[0];
  assign BusMuxInR1      = r[1];
  assign BusMuxInR2      = r[2];
  assign BusMuxInR3      = r[3];
  assign BusMuxInR4      = r[4];
  assign BusMuxInR5      = r[5];
  assign BusMuxInR6      = r[6];
  assign BusMuxInR7      = r[7];
  assign BusMuxInR8      = r[8];
  assign BusMuxInR9      = r[9];
  assign BusMuxInR10     = r[10];
  assign BusMuxInR11     = r[11];
  assign BusMuxInR12     = r[12];
  assign BusMuxInR13     = r[13];
  assign BusMuxInR14     = r[14];
  assign BusMuxInR15     = r[15];
  assign BusMuxInHI      = hi;
  assign BusMuxInLO      = lo;
  assign BusMuxInZhi     = z[2*DATA_W-1:DATA_W];
  assign BusMuxInZlo     = z[DATA_W-1:0];
  assign BusMuxInPC      = pc;
  assign BusMuxInMDR     = mdr;
  assign BusMuxInInport  = inport;
  assign BusMuxInOutport = outport;
  assign BusMuxInY       = y;
  assign IRregister      = ir;
  assign Cregister       = c_ext;
  assign marToRam        = mar[8:0];

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the datapath: fetch, ALU, branch, bus priority, reset.
module tb_datapath;
  logic Clock = 1'b0;
  logic Clear = 1'b1;
  logic HIin = 0, LOin = 0, PCin = 0, MDRin = 0, Zin = 0, Yin = 0, MARin = 0, IRin = 0, CONin = 0, OUTPORTin = 0;
  logic HIout = 0, LOout = 0, ZHIout = 0, ZLOout = 0, PCout = 0, MDRout = 0, INPORTout = 0, OUTPORTout = 0, Cout = 0, Yout = 0;
  logic Gra = 0, Grb = 0, Grc = 0, Rin = 0, Rout = 0, BAout = 0;
  logic Read = 0, write = 0, IncPC = 0;
  logic [31:0] inportInput = '0;
  logic [15:0] regIn = '0;
  logic [31:0] busMuxOut;
  logic [4:0]  encoderOut;
  logic        CON;
  logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14, R15;
  logic [31:0] HI, LO, ZHI, ZLO, PC, MDR, INP, OUTP, Y, IR, C;
  logic [8:0]  mar;

  int checks = 0;
  int failures = 0;

  localparam int D_IR = 0, D_Y = 1, D_MAR = 2, D_MDR = 3, D_PC = 4;
  localparam int D_HI = 5, D_LO = 6, D_REG = 7, D_OUT = 8;

  always #5 Clock = ~Clock;

  datapath dut (
    .Clock(Clock), .Clear(Clear),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .OUTPORTout(OUTPORTout), .Cout(Cout), .Yout(Yout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .write(write), .IncPC(IncPC),
    .inportInput(inportInput), .regIn(regIn),
    .busMuxOut(busMuxOut), .encoderOut(encoderOut), .CON(CON),
    .BusMuxInR0(R0), .BusMuxInR1(R1), .BusMuxInR2(R2), .BusMuxInR3(R3),
    .BusMuxInR4(R4), .BusMuxInR5(R5), .BusMuxInR6(R6), .BusMuxInR7(R7),
    .BusMuxInR8(R8), .BusMuxInR9(R9), .BusMuxInR10(R10), .BusMuxInR11(R11),
    .BusMuxInR12(R12), .BusMuxInR13(R13), .BusMuxInR14(R14), .BusMuxInR15(R15),
    .BusMuxInHI(HI), .BusMuxInLO(LO), .BusMuxInZhi(ZHI), .BusMuxInZlo(ZLO),
    .BusMuxInPC(PC), .BusMuxInMDR(MDR), .BusMuxInInport(INP), .BusMuxInOutport(OUTP),
    .BusMuxInY(Y), .IRregister(IR), .Cregister(C), .marToRam(mar)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    HIin = 0; LOin = 0; PCin = 0; MDRin = 0; Zin = 0; Yin = 0; MARin = 0; IRin = 0; CONin = 0; OUTPORTin = 0;
    HIout = 0; LOout = 0; ZHIout = 0; ZLOout = 0; PCout = 0; MDRout = 0; INPORTout = 0; OUTPORTout = 0; Cout = 0; Yout = 0;
    Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
    Read = 0; write = 0; IncPC = 0; regIn = '0;
  endtask

  // Put a value on the bus through the input port and load one destination.
  task automatic via_inport(input logic [31:0] v, input int dst, input logic [15:0] mask = 16'h0);
    inportInput = v;
    step();
    INPORTout = 1;
    case (dst)
      D_IR:    IRin = 1;
      D_Y:     Yin = 1;
      D_MAR:   MARin = 1;
      D_MDR:   MDRin = 1;
      D_PC:    PCin = 1;
      D_HI:    HIin = 1;
      D_LO:    LOin = 1;
      D_REG:   regIn = mask;
      D_OUT:   OUTPORTin = 1;
      default: ;
    endcase
    step();
    idle();
  endtask

  task automatic alu_run(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    via_inport({op, 27'b0}, D_IR);
    via_inport(a, D_Y);
    inportInput = b;
    step();
    INPORTout = 1;
    Zin = 1;
    step();
    idle();
    check(tag, {ZHI, ZLO}, exp);
  endtask

  task automatic con_run(input string tag, input logic [31:0] irv, input logic [31:0] b, input logic exp);
    via_inport(irv, D_IR);
    inportInput = b;
    step();
    INPORTout = 1;
    CONin = 1;
    step();
    idle();
    check(tag, 64'(CON), 64'(exp));
  endtask

  initial begin
    // Reset state
    #3 Clear = 0;
    step();
    step();
    check("rst_pc", 64'(PC), 64'h0);
    check("rst_ir", 64'(IR), 64'h0);
    check("rst_z", {ZHI, ZLO}, 64'h0);
    check("rst_con", 64'(CON), 64'h0);
    check("rst_enc", 64'(encoderOut), 64'd31);
    check("rst_bus", 64'(busMuxOut), 64'h0);
    Clear = 1;

    // Preload RAM[18] through MAR/MDR, then scramble MAR and MDR
    via_inport(32'd18, D_MAR);
    check("prep_mar", 64'(mar), 64'd18);
    via_inport(32'hB180_0000, D_MDR);
    check("prep_mdr", 64'(MDR), 64'hB180_0000);
    write = 1;
    step();
    idle();
    via_inport(32'd0, D_MDR);
    via_inport(32'd7, D_MAR);

    // Input-port fetch
    inportInput = 32'd18;
    step();
    INPORTout = 1; PCin = 1;
    #1 check("fetch_enc_in", 64'(encoderOut), 64'd22);
    step(); idle();
    check("fetch_pc18", 64'(PC), 64'd18);
    PCout = 1; MARin = 1;
    step(); idle();
    check("fetch_mar", 64'(mar), 64'd18);
    Read = 1; MDRin = 1; PCin = 1; IncPC = 1;
    step(); idle();
    check("fetch_mdr", 64'(MDR), 64'hB180_0000);
    check("fetch_pc19", 64'(PC), 64'd19);
    MDRout = 1; IRin = 1;
    step(); idle();
    check("fetch_ir", 64'(IR), 64'hB180_0000);
    Gra = 1; Rin = 1; INPORTout = 1;
    #1 check("fetch_enc", 64'(encoderOut), 64'd22);
    step(); idle();
    check("fetch_r3", 64'(R3), 64'd18);

    // Add through Y and Z
    via_inport(32'd5, D_REG, 16'h0002);
    via_inport(32'd7, D_REG, 16'h0004);
    check("add_r1", 64'(R1), 64'd5);
    check("add_r2", 64'(R2), 64'd7);
    via_inport(32'h1890_0000, D_IR);
    Gra = 1; Rout = 1; Yin = 1;
    step(); idle();
    check("add_y", 64'(Y), 64'd5);
    Grb = 1; Rout = 1; Zin = 1;
    step(); idle();
    check("add_z", {ZHI, ZLO}, 64'd12);
    ZLOout = 1;
    #1 check("add_bus", 64'(busMuxOut), 64'd12);
    check("add_enc", 64'(encoderOut), 64'd19);
    idle();

    // ALU operations
    alu_run("mul", 5'b01111, 32'hFFFF_FFFD, 32'd4, 64'hFFFF_FFFF_FFFF_FFF4);
    alu_run("div", 5'b10000, 32'd7, 32'd2, {32'd1, 32'd3});
    alu_run("div_neg", 5'b10000, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    alu_run("div_zero", 5'b10000, 32'd7, 32'd0, 64'h0);
    alu_run("sub", 5'b00100, 32'd10, 32'd3, 64'd7);
    alu_run("shr", 5'b00101, 32'h8000_0000, 32'd4, 64'h0800_0000);
    alu_run("shra", 5'b00110, 32'h8000_0000, 32'd4, 64'hF800_0000);
    alu_run("shl", 5'b00111, 32'd1, 32'd31, 64'h8000_0000);
    alu_run("ror", 5'b01000, 32'd1, 32'd1, 64'h8000_0000);
    alu_run("rol", 5'b01001, 32'h8000_0001, 32'd1, 64'h0000_0003);
    alu_run("and", 5'b01010, 32'h0000_F0F0, 32'h0000_FF00, 64'h0000_F000);
    alu_run("or", 5'b01110, 32'h0000_00F0, 32'h0000_000F, 64'h0000_00FF);
    alu_run("neg", 5'b10001, 32'd0, 32'd5, 64'hFFFF_FFFB);
    alu_run("not", 5'b10010, 32'd0, 32'd0, 64'hFFFF_FFFF);
    alu_run("add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'd2, 64'd1);

    // Branch conditions
    con_run("con_eq0", 32'h0000_0000, 32'd0, 1'b1);
    con_run("con_neg", 32'h0018_0000, 32'd5, 1'b0);
    con_run("con_ne0", 32'h0008_0000, 32'd5, 1'b1);
    con_run("con_pos", 32'h0010_0000, 32'h8000_0000, 1'b0);

    // BAout on R0 yields zero, Rout on R0 yields the contents
    via_inport(32'd9, D_REG, 16'h0001);
    check("r0_load", 64'(R0), 64'd9);
    via_inport(32'h0, D_IR);
    Grb = 1; BAout = 1;
    #1 check("baout_bus", 64'(busMuxOut), 64'd0);
    check("baout_enc", 64'(encoderOut), 64'd0);
    idle();
    Grb = 1; Rout = 1;
    #1 check("rout_r0", 64'(busMuxOut), 64'd9);
    idle();

    // Grc selects Rc
    via_inport(32'h0001_8000, D_IR);
    Grc = 1; Rout = 1;
    #1 check("grc_r3", 64'(busMuxOut), 64'd18);
    idle();

    // Bus priority and remaining sources
    via_inport(32'hAA, D_HI);
    via_inport(32'hBB, D_LO);
    HIout = 1; LOout = 1;
    #1 check("prio_hi_bus", 64'(busMuxOut), 64'hAA);
    check("prio_hi_enc", 64'(encoderOut), 64'd16);
    idle();
    PCout = 1; Yout = 1;
    #1 check("prio_pc_bus", 64'(busMuxOut), 64'd19);
    check("prio_pc_enc", 64'(encoderOut), 64'd20);
    idle();
    via_inport(32'h0004_0001, D_IR);
    check("c_sext", 64'(C), 64'hFFFC_0001);
    Cout = 1;
    #1 check("c_bus", 64'(busMuxOut), 64'hFFFC_0001);
    check("c_enc", 64'(encoderOut), 64'd23);
    idle();
    via_inport(32'h55, D_OUT);
    OUTPORTout = 1;
    #1 check("out_bus", 64'(busMuxOut), 64'h55);
    check("out_enc", 64'(encoderOut), 64'd25);
    idle();

    // Asynchronous clear mid-cycle, loads blocked while low
    alu_run("pre_clr_z", 5'b10110, 32'd1, 32'd2, 64'd3);
    #2 Clear = 0;
    #1;
    check("clr_pc", 64'(PC), 64'h0);
    check("clr_ir", 64'(IR), 64'h0);
    check("clr_r3", 64'(R3), 64'h0);
    check("clr_z", {ZHI, ZLO}, 64'h0);
    IncPC = 1;
    step();
    check("clr_block", 64'(PC), 64'h0);
    Clear = 1;
    step();
    idle();
    check("clr_resume", 64'(PC), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
